// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_pkg
// Description : Opcode and FSM state encodings shared by the command slave.
// Revision    : 1.0
// ============================================================================
package cmd_pkg;

    localparam int c_DEPTH    = 16;
    localparam int c_WALK_LEN = c_DEPTH - 1;

    typedef enum logic [3:0] {
        CMD_NOP   = 4'd0,
        CMD_WRITE = 4'd1,
        CMD_READ  = 4'd2,
        CMD_INC   = 4'd3,
        CMD_FILL  = 4'd4,
        CMD_CLEAR = 4'd5
    } cmd_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cmd_regfile_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : cmd_regfile_slave_if
// Description : Command bus between a command master and the register slave.
// Revision    : 1.0
// ============================================================================
interface cmd_regfile_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              carry;
    logic              busy;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output cmd, adr, data,
        input  rsp_valid, rsp_data, carry, busy, err_cnt, drop_cnt
    );

    modport slave (
        input  cmd, adr, data,
        output rsp_valid, rsp_data, carry, busy, err_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cmd_regfile
// Description : DEPTH x DATA_W storage, one sync write port, one comb read port.
// Revision    : 1.0
// ============================================================================
module cmd_regfile #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_wadr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_radr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wadr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_radr];

endmodule
`default_nettype wire

// File: rtl/cmd_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : cmd_regfile_slave
// Description : Executes bus commands against a register file; FILL/CLEAR walks.
// Revision    : 1.0
// ============================================================================
module cmd_regfile_slave
    import cmd_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    cmd_regfile_slave_if.slave   bus
);

    localparam logic [ADDR_W-1:0] c_LAST_STEP = ADDR_W'(DEPTH - 2);

    state_e              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr,   w_ptr_nxt;
    logic [ADDR_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [DATA_W-1:0]   r_fill,  w_fill_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_data,  w_rsp_data_nxt;
    logic                r_carry,     w_carry_nxt;
    logic [CNT_W-1:0]    r_err_cnt, r_drop_cnt;
    logic                w_err_inc, w_drop_inc;
    logic                w_we;
    logic [ADDR_W-1:0]   w_wadr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W:0]     w_sum;

    cmd_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_wadr  (w_wadr),
        .i_wdata (w_wdata),
        .i_radr  (bus.adr),
        .o_rdata (w_rdata)
    );

    assign w_sum = {1'b0, w_rdata} + {1'b0, bus.data};

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_fill_nxt      = r_fill;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_carry_nxt     = r_carry;
        w_err_inc       = 1'b0;
        w_drop_inc      = 1'b0;
        w_we            = 1'b0;
        w_wadr          = bus.adr;
        w_wdata         = bus.data;

        unique case (r_state)
            ST_IDLE: begin
                case (bus.cmd)
                    CMD_NOP: ;
                    CMD_WRITE: w_we = 1'b1;
                    CMD_READ: begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = w_rdata;
                    end
                    CMD_INC: begin
                        w_we        = 1'b1;
                        w_wdata     = w_sum[DATA_W-1:0];
                        w_carry_nxt = w_sum[DATA_W];
                    end
                    CMD_FILL: begin
                        w_we        = 1'b1;
                        w_ptr_nxt   = bus.adr + ADDR_W'(1);
                        w_fill_nxt  = bus.data;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WALK;
                    end
                    CMD_CLEAR: begin
                        w_we        = 1'b1;
                        w_wadr      = '0;
                        w_wdata     = '0;
                        w_ptr_nxt   = ADDR_W'(1);
                        w_fill_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WALK;
                    end
                    // Undefined opcodes, including unknown values, land here.
                    default: w_err_inc = 1'b1;
                endcase
            end
            ST_WALK: begin
                w_we       = 1'b1;
                w_wadr     = r_ptr;
                w_wdata    = r_fill;
                w_ptr_nxt  = r_ptr + ADDR_W'(1);
                w_cnt_nxt  = r_cnt + ADDR_W'(1);
                w_drop_inc = (bus.cmd != CMD_NOP);
                if (r_cnt == c_LAST_STEP) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_fill      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_carry     <= 1'b0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fill      <= w_fill_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_carry     <= w_carry_nxt;
            if (w_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_drop_inc && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.carry     = r_carry;
    assign bus.busy      = (r_state == ST_WALK);
    assign bus.err_cnt   = r_err_cnt;
    assign bus.drop_cnt  = r_drop_cnt;

    a_cmd_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(bus.cmd));

endmodule
`default_nettype wire

// File: tb/tb_cmd_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_regfile_slave
// Description : Directed self-checking bench for cmd_regfile_slave.
// Revision    : 1.0
// ============================================================================
module tb_cmd_regfile_slave;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_cycles;
    logic seen_rsp;

    always #5 clk = ~clk;

    cmd_regfile_slave_if #(.ADDR_W(4), .DATA_W(4), .CNT_W(8)) bus ();

    cmd_regfile_slave #(
        .DEPTH  (16),
        .ADDR_W (4),
        .DATA_W (4),
        .CNT_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
        bus.cmd  = c;
        bus.adr  = a;
        bus.data = d;
    endtask

    task automatic exec(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
        drive(c, a, d);
        tick();
        drive(4'd0, 4'd0, 4'd0);
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [3:0] exp, input string tag);
        exec(4'd2, a, 4'd0);
        check_val({tag, "_valid"}, bus.rsp_valid, 1);
        check_val({tag, "_data"},  bus.rsp_data,  exp);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(4'd0, 4'd0, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_rsp_valid", bus.rsp_valid, 0);
        check_val("rst_rsp_data",  bus.rsp_data,  0);
        check_val("rst_carry",     bus.carry,     0);
        check_val("rst_busy",      bus.busy,      0);
        check_val("rst_err",       bus.err_cnt,   0);
        check_val("rst_drop",      bus.drop_cnt,  0);

        // Write then read, response one cycle after sampling, then data held
        exec(4'd1, 4'd3, 4'd9);
        read_chk(4'd3, 4'd9, "wr_rd3");
        tick();
        check_val("rsp_valid_drop", bus.rsp_valid, 0);
        check_val("rsp_data_hold",  bus.rsp_data,  9);

        // INC with and without carry
        exec(4'd1, 4'd5, 4'd12);
        exec(4'd3, 4'd5, 4'd7);
        check_val("inc1_carry", bus.carry, 1);
        read_chk(4'd5, 4'd3, "inc1_mem");
        check_val("carry_hold_on_read", bus.carry, 1);
        exec(4'd3, 4'd5, 4'd1);
        check_val("inc2_carry", bus.carry, 0);
        read_chk(4'd5, 4'd4, "inc2_mem");

        // FILL with wrap; READ issued during the walk is dropped
        exec(4'd4, 4'd14, 4'd6);
        check_val("fill_busy_start", bus.busy, 1);
        busy_cycles = 1;
        seen_rsp    = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 1) drive(4'd2, 4'd0, 4'd0);
            else        drive(4'd0, 4'd0, 4'd0);
            tick();
            if (bus.rsp_valid) seen_rsp = 1'b1;
            if (bus.busy)      busy_cycles++;
        end
        drive(4'd0, 4'd0, 4'd0);
        check_val("fill_busy_cycles", busy_cycles, 15);
        check_val("fill_no_rsp",      seen_rsp,    0);
        check_val("fill_drop",        bus.drop_cnt, 1);
        check_val("fill_busy_end",    bus.busy,    0);
        for (int a = 0; a < 16; a++) begin
            read_chk(4'(a), 4'd6, $sformatf("fill_rd%0d", a));
        end

        // FILL, then CLEAR aborted by reset at walk step 7
        exec(4'd4, 4'd0, 4'd15);
        repeat (15) tick();
        check_val("fill2_idle", bus.busy, 0);
        exec(4'd5, 4'd9, 4'd9);
        repeat (6) tick();
        check_val("clear_busy_mid", bus.busy, 1);
        pulse_reset();
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_drop", bus.drop_cnt, 0);
        tick();
        check_val("abort_stays_idle", bus.busy, 0);
        for (int a = 0; a < 16; a++) begin
            read_chk(4'(a), 4'd0, $sformatf("abort_rd%0d", a));
        end
        exec(4'd1, 4'd7, 4'd5);
        read_chk(4'd7, 4'd5, "post_abort_wr");
        check_val("post_abort_drop", bus.drop_cnt, 0);

        // Boundary: illegal in walk is a drop; WRITE at N+15 dropped, at N+16 executed
        exec(4'd4, 4'd8, 4'd3);
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) drive(4'd9, 4'd0, 4'd0);
            else        drive(4'd0, 4'd0, 4'd0);
            tick();
        end
        check_val("walk_illegal_err",  bus.err_cnt,  0);
        check_val("walk_illegal_drop", bus.drop_cnt, 1);
        check_val("walk_busy_n15",     bus.busy,     1);
        exec(4'd1, 4'd2, 4'd1);
        check_val("n15_write_dropped", bus.drop_cnt, 2);
        check_val("n16_busy",          bus.busy,     0);
        exec(4'd1, 4'd2, 4'd1);
        check_val("n16_write_kept",    bus.drop_cnt, 2);
        read_chk(4'd2, 4'd1, "n16_rd2");
        read_chk(4'd7, 4'd3, "fill3_rd7");

        // Illegal opcodes in IDLE saturate err_cnt
        pulse_reset();
        drive(4'd9, 4'd0, 4'd0);
        repeat (10) tick();
        check_val("err_10", bus.err_cnt, 10);
        repeat (290) tick();
        drive(4'd0, 4'd0, 4'd0);
        check_val("err_sat",      bus.err_cnt,  255);
        check_val("err_sat_drop", bus.drop_cnt, 0);
        check_val("err_sat_busy", bus.busy,     0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
